// File: rtl/serial_adder_seq.sv
// -----------------------------------------------------------------------------
// serial_adder_seq
//
// Bit-serial adder with its own sequencer. An accepted start captures the two
// operands, one LOAD cycle clears (or presets) the carry, then WIDTH SHIFT
// cycles push operand bits LSB-first through a single full-adder cell. The sum
// is assembled by shifting each result bit in at the MSB end of sum. The
// registered sum/cout are then presented together with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   -> a sub port exists; sub=1 computes a-b (mod 2^WIDTH) by
//                loading ~b and presetting the carry to 1. cout=1 means no
//                borrow.
//   undefined -> add only; the carry always starts at 0.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   start   in   request, sampled only in IDLE and DONE
//   a, b    in   WIDTH-bit operands, captured on an accepted start
//   sub     in   subtract select (SERIAL_ADDER_SUB_EN only)
//   load    out  high for the single LOAD cycle
//   enable  out  high during every SHIFT cycle
//   busy    out  high in LOAD and SHIFT
//   done    out  one-cycle pulse in DONE
//   sum     out  WIDTH-bit result, valid from DONE until the next LOAD
//   cout    out  final carry, valid alongside sum
//
// State table
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the previous result
//   LOAD  | operands captured; carry and bit counter initialised
//   SHIFT | one operand bit per cycle through the full adder
//   DONE  | result presented, done=1; start here chains the next operation
// -----------------------------------------------------------------------------
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             load,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("serial_adder_seq: WIDTH must be in 2..64");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               sub_q;
    logic [CNT_W-1:0]   count_q;

    logic               sub_sel;
    logic               accept;
    logic               last_bit;
    logic               sum_bit;
    logic               carry_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    always_comb sub_sel = sub;
`else
    always_comb sub_sel = 1'b0;
`endif

    // start only matters when the sequencer is free to take new operands
    always_comb accept = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb last_bit = (count_q == CNT_W'(WIDTH - 1));

    // single full-adder cell on the current LSBs
    always_comb begin
        sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        enable  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                enable = 1'b1;
                busy   = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        opa_q <= a;
                        // subtraction is a + ~b + 1; the +1 comes from the carry preset
                        opb_q <= sub_sel ? ~b : b;
                        sub_q <= sub_sel;
                    end
                end
                LOAD: begin
                    carry_q <= sub_q;
                    count_q <= '0;
                end
                SHIFT: begin
                    opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
                    opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
                    sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
                    carry_q <= carry_nxt;
                    count_q <= count_q + CNT_W'(1);
                    // capture the final carry on the last bit so it is
                    // already stable for the whole DONE cycle
                    if (last_bit) begin
                        cout_q <= carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             load;
    logic             enable;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub    (sub),
`endif
        .load   (load),
        .enable (enable),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected results, {cout, sum}, in issue order
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: pops the scoreboard on every done and checks per-operation
    // LOAD/SHIFT cycle counts.
    // -------------------------------------------------------------------------
    initial begin
        int             en_cnt;
        int             load_cnt;
        logic           prev_done;
        logic [WIDTH:0] e;
        en_cnt    = 0;
        load_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_cnt    = 0;
                load_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                check("busy_vs_load_enable", 64'(busy), 64'(load | enable));
                if (load)   load_cnt++;
                if (enable) en_cnt++;
                if (done) begin
                    check("done_single_cycle", 64'(prev_done), 64'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=done required=no_done sum=%0h", sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
                        check("cout", 64'(cout), 64'(e[WIDTH]));
                    end
                    check("load_cycles", 64'(load_cnt), 64'(1));
                    check("enable_cycles", 64'(en_cnt), 64'(WIDTH));
                    load_cnt = 0;
                    en_cnt   = 0;
                end
                prev_done = done;
            end
        end
    end

    // Counts clock edges until done is seen; timeout counts as a failure.
    task automatic wait_done(output int n);
        n = 0;
        repeat (WIDTH + 6) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=no_done required=done_within_%0d", WIDTH + 6);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] es, input logic ec);
        int n;
        @(posedge clk);
        #1;
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back({ec, es});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("latency", 64'(n), 64'(WIDTH + 1));
        @(posedge clk);
        @(negedge clk);
        check("sum_hold_idle", 64'(sum), 64'(es));
        check("idle_after_done", 64'(busy | done), 64'(0));
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic run_sub(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic [WIDTH-1:0] es, input logic ec);
        sub = 1'b1;
        run_op(av, bv, es, ec);
        sub = 1'b0;
    endtask
`endif

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_load",   64'(load),   64'(0));
        check("rst_enable", 64'(enable), 64'(0));
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_sum",    64'(sum),    64'(0));
        check("rst_cout",   64'(cout),   64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // basic add and overflow cases
        run_op(8'h35, 8'h4A, 8'h7F, 1'b0);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(8'h80, 8'h80, 8'h00, 1'b1);

        // reset during the 4th SHIFT cycle discards the operation
        @(posedge clk);
        #1;
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_load",   64'(load),   64'(0));
        check("midrst_enable", 64'(enable), 64'(0));
        check("midrst_busy",   64'(busy),   64'(0));
        check("midrst_done",   64'(done),   64'(0));
        check("midrst_sum",    64'(sum),    64'(0));
        check("midrst_cout",   64'(cout),   64'(0));
        run_op(8'h01, 8'h02, 8'h03, 1'b0);

        // start pulsed during SHIFT is ignored
        @(posedge clk);
        #1;
        a     = 8'h05;
        b     = 8'h06;
        start = 1'b1;
        exp_q.push_back({1'b0, 8'h0B});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        repeat (WIDTH + 4) @(posedge clk);
        @(negedge clk);
        check("ignored_start_sum", 64'(sum), 64'(8'h0B));
        check("ignored_start_idle", 64'(busy), 64'(0));

        // back-to-back: start held, second operands presented at DONE
        @(posedge clk);
        #1;
        a     = 8'h0F;
        b     = 8'h01;
        start = 1'b1;
        exp_q.push_back({1'b0, 8'h10});
        @(posedge clk);
        #1;
        a     = 8'h20;
        b     = 8'h03;
        exp_q.push_back({1'b0, 8'h23});
        wait_done(n);
        check("b2b_latency1", 64'(n), 64'(WIDTH + 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_load_after_done", 64'(load), 64'(1));
        wait_done(n);
        check("b2b_latency2", 64'(n), 64'(WIDTH + 1));

`ifdef SERIAL_ADDER_SUB_EN
        run_sub(8'h10, 8'h01, 8'h0F, 1'b1);
        run_sub(8'h00, 8'h01, 8'hFF, 1'b0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Parametrised bit-serial adder with integrated sequencer: captures two WIDTH-bit operands on a start request, adds them LSB-first through a single full-adder cell over WIDTH shift cycles, and presents the registered sum and carry-out with a one-cycle done pulse. It is the next-generation serial_adder block: the controller and datapath are merged, the shift length is counted from WIDTH, and a busy/done handshake is added. It sits between the operand source and the result consumer in the serial_adder subsystem.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), localparam; shift counter width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE and DONE.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- sub  in  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- load  out  1  high for the single LOAD cycle.
- enable  out  1  high during every SHIFT cycle.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle pulse in DONE.
- sum  out  WIDTH  result; valid from DONE until the next LOAD.
- cout  out  1  final carry; valid alongside sum.

## Operation
- States: IDLE, LOAD, SHIFT, DONE, in a 2-bit register.
- IDLE: start=1 captures a and b (plus sub) into opA_q and opB_q, then goes to LOAD. start=0 stays in IDLE.
- LOAD: load=1. Clears the carry (sets it to 1 when subtracting) and sets count=0. Always goes to SHIFT.
- SHIFT: enable=1.
  - Computes s = opA_q[0] ^ opB_q[0] ^ carry.
  - Shifts opA_q and opB_q right by 1.
  - Shifts s into sum at bit WIDTH-1; sum shifts right.
  - Updates carry to majority(opA_q[0], opB_q[0], carry).
  - count += 1. When count == WIDTH-1 (the last bit), goes to DONE.
- DONE: done=1 and cout=carry. sum and cout hold.
  - start=1 is accepted exactly as in IDLE (back-to-back operation) and goes to LOAD.
  - Otherwise goes to IDLE. sum and cout keep holding there.
- start during LOAD or SHIFT is ignored. There is no abort or restart.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.
- sum and cout are not cleared at LOAD. They are overwritten by shifting, and cout updates in DONE.
- During SHIFT, sum contents are intermediate. Consumers use sum only on done or afterwards.

## Timing
- Reset: state=IDLE; load=enable=busy=done=cout=0; sum=0; operand registers, carry and count =0.
- reset takes priority over every state and over start, including mid-SHIFT. The current operation is discarded, and the cycle after the reset edge shows reset values.
- start is sampled high at edge E0. The timeline is:
  - E0 to E1: LOAD.
  - E1 to E1+WIDTH: SHIFT.
  - Cycle after edge E1+WIDTH: DONE, with done=1.
- Latency from the start edge to the done cycle is WIDTH+1 clocks. Throughput is one result per WIDTH+2 cycles with back-to-back starts.
- All outputs are registered or decoded from the state register only. No input reaches an output combinationally.
- When start is accepted in DONE, done=1 in that cycle and load=1 in the next cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined: the sub port exists and is captured with the operands.
  - sub=1: opB_q is loaded as ~b and carry is initialised to 1 in LOAD, so sum = a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
- Not defined: the sub port is absent and the carry always initialises to 0 (add only).

## Test plan
- Basic add, WIDTH=8: reset, then start with a=0x35, b=0x4A. Expected: load for 1 cycle, enable for 8 cycles, then done with sum=0x7F, cout=0. done is high 9 clocks after the start edge.
- Overflow: a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1.
- Reset mid-operation: assert reset on the 4th SHIFT cycle. Expected: next cycle state IDLE, all outputs 0. A new start with a=0x01, b=0x02 yields sum=0x03.
- Start ignored while busy: pulse start with a=0x11, b=0x22 during SHIFT of an operation with a=0x05, b=0x06. Expected: one done only, with sum=0x0B. No second LOAD.
- Back-to-back: hold start=1 with a=0x0F, b=0x01 and then a=0x20, b=0x03 presented at DONE. Expected: first done with sum=0x10, load the next cycle, second done with sum=0x23.
- With SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1.
  - sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.
